test_pattern_gen: RTL and testbench

Synthesizable multi-channel sample-stream generator that replaces the free-running stimulus counter with a configurable source. It drives CH lanes of DW-bit samples into the ADC capture/trigger path through a valid/ready handshake. It is used both in simulation and as an on-chip self-test source. Modes are increment, decrement, triangle and, optionally, LFSR. A programmable rate divider sets the sample rate, and backpressure stalls generation without dropping samples.

---
 rtl/test_pattern_gen.sv | 139 +++++++++++++
 tb/tb_test_pattern_gen.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/test_pattern_gen.sv
// test_pattern_gen: multi-lane sample-stream generator with increment, decrement,
// triangle and optional LFSR modes, a programmable rate divider, and a
// valid/ready output that stalls generation without dropping samples.
// Build option: define TEST_PATTERN_GEN_LFSR_EN to make mode 3 a Galois LFSR;
// without it mode 3 behaves exactly like mode 0.
module test_pattern_gen #(
  parameter int            DW   = 10,
  parameter int            CH   = 2,
  parameter int            DIVW = 8,
  parameter logic [DW-1:0] POLY = 10'h240
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [1:0]       mode,
  input  logic [DW-1:0]    step,
  input  logic [DW-1:0]    seed,
  input  logic [DIVW-1:0]  div,
  output logic [CH*DW-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             wrap
);

  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_t;

  localparam int            OFS = (2 ** DW) / CH;
  localparam logic [DW-1:0] MAX = '1;

  logic [DW-1:0]    acc, acc_nxt, load_val;
  dir_t             dir, dir_nxt;
  logic             wrap_nxt, wrap_pend;
  logic [DIVW-1:0]  dcnt;
  logic             stall, adv, tick;
  logic [CH*DW-1:0] lanes;

  assign stall = out_valid && !out_ready;
  assign adv   = en && !load && !stall;
  assign tick  = adv && (dcnt == div);

`ifdef TEST_PATTERN_GEN_LFSR_EN
  // The all-zero state is a dead state for the LFSR, so seed 0 means "start at 1".
  logic [DW-1:0] lfsr_home;
  assign lfsr_home = (seed == '0) ? DW'(1) : seed;
  assign load_val  = (mode == 2'd3) ? lfsr_home : seed;
`else
  logic unused_poly;
  assign unused_poly = ^POLY;
  assign load_val    = seed;
`endif

  // Next accumulator value, direction and period-wrap flag for the current mode.
  always_comb begin
    acc_nxt  = acc;
    dir_nxt  = dir;
    wrap_nxt = 1'b0;
    case (mode)
      2'd0: {wrap_nxt, acc_nxt} = {1'b0, acc} + {1'b0, step};
      2'd1: begin
        acc_nxt  = acc - step;
        wrap_nxt = (acc < step);
      end
      2'd2: begin
        if (dir == DIR_UP) begin
          if (acc > MAX - step) begin
            acc_nxt  = MAX;
            dir_nxt  = DIR_DOWN;
            wrap_nxt = 1'b1;
          end else begin
            acc_nxt = acc + step;
          end
        end else begin
          if (acc < step) begin
            acc_nxt  = '0;
            dir_nxt  = DIR_UP;
            wrap_nxt = 1'b1;
          end else begin
            acc_nxt = acc - step;
          end
        end
      end
      default: begin
`ifdef TEST_PATTERN_GEN_LFSR_EN
        acc_nxt  = (acc >> 1) ^ (acc[0] ? POLY : '0);
        wrap_nxt = (acc_nxt == lfsr_home);
`else
        {wrap_nxt, acc_nxt} = {1'b0, acc} + {1'b0, step};
`endif
      end
    endcase
  end

  // Channel k is the accumulator offset by k evenly spaced fractions of full scale.
  always_comb begin
    lanes = '0;
    for (int k = 0; k < CH; k++) begin
      lanes[k*DW +: DW] = acc + DW'(k * OFS);
    end
  end

  // Generator state and output registers; the wrap of a transition is held in
  // wrap_pend so it is flagged on the sample that carries the wrapped value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc       <= '0;
      dir       <= DIR_UP;
      dcnt      <= '0;
      wrap_pend <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      wrap      <= 1'b0;
    end else if (load) begin
      acc       <= load_val;
      dir       <= DIR_UP;
      dcnt      <= '0;
      wrap_pend <= 1'b0;
      out_valid <= 1'b0;
      wrap      <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (tick) begin
        dcnt      <= '0;
        acc       <= acc_nxt;
        dir       <= dir_nxt;
        wrap_pend <= wrap_nxt;
        wrap      <= wrap_pend;
        out_data  <= lanes;
        out_valid <= 1'b1;
      end else if (adv) begin
        dcnt <= dcnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_test_pattern_gen.sv
// tb_test_pattern_gen: randomized and directed stimulus for test_pattern_gen,
// checked every cycle against a sample-level reference model.
`timescale 1ns/1ps
module tb_test_pattern_gen;

  localparam int DW   = 10;
  localparam int CH   = 2;
  localparam int DIVW = 8;
  localparam int MOD  = 1 << DW;
  localparam int MAXV = MOD - 1;
  localparam int OFS  = MOD / CH;

  logic             clk       = 1'b0;
  logic             reset     = 1'b1;
  logic             en        = 1'b0;
  logic             load      = 1'b0;
  logic             out_ready = 1'b1;
  logic [1:0]       mode      = 2'd0;
  logic [DW-1:0]    step      = 10'd1;
  logic [DW-1:0]    seed      = 10'd0;
  logic [DIVW-1:0]  div       = 8'd0;
  logic [CH*DW-1:0] out_data;
  logic             out_valid;
  logic             wrap;

  int nvec = 0;
  int nerr = 0;

  // reference model state
  int m_acc, m_up, m_pend, m_cnt, m_valid, m_wrap, m_tick;
  logic [CH*DW-1:0] m_data;

  logic [CH*DW-1:0] cap_d[$];
  logic             cap_w[$];
  logic [CH*DW-1:0] tv;

  int tri_exp[10] = '{0, 300, 600, 900, 1023, 723, 423, 123, 0, 300};
  int tri_wr[10]  = '{0, 0, 0, 0, 1, 0, 0, 0, 1, 0};

  test_pattern_gen dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .load      (load),
    .mode      (mode),
    .step      (step),
    .seed      (seed),
    .div       (div),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .wrap      (wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [CH*DW-1:0] lanes_of(input int a);
    logic [CH*DW-1:0] v;
    v = '0;
    for (int k = 0; k < CH; k++) v[k*DW +: DW] = DW'((a + k * OFS) % MOD);
    return v;
  endfunction

  task automatic model_reset();
    m_acc = 0; m_up = 1; m_pend = 0; m_cnt = 0;
    m_valid = 0; m_wrap = 0; m_tick = 0; m_data = '0;
  endtask

  // Value sequence rules, in plain integer arithmetic.
  task automatic model_adv(input int md, input int st, input int sd);
    int s;
    int eff;
    eff = md;
`ifndef TEST_PATTERN_GEN_LFSR_EN
    if (eff == 3) eff = 0;
`endif
    m_pend = 0;
    case (eff)
      0: begin s = m_acc + st; m_pend = (s > MAXV) ? 1 : 0; m_acc = s % MOD; end
      1: begin s = m_acc - st; m_pend = (s < 0) ? 1 : 0; m_acc = (s + MOD) % MOD; end
      2: begin
        if (m_up != 0) begin
          if (m_acc + st > MAXV) begin m_acc = MAXV; m_up = 0; m_pend = 1; end
          else m_acc = m_acc + st;
        end else begin
          if (m_acc - st < 0) begin m_acc = 0; m_up = 1; m_pend = 1; end
          else m_acc = m_acc - st;
        end
      end
      default: begin
        m_acc  = (m_acc / 2) ^ (((m_acc % 2) != 0) ? 'h240 : 0);
        m_pend = (m_acc == ((sd == 0) ? 1 : sd)) ? 1 : 0;
      end
    endcase
  endtask

  // One clock edge of the model: count qualifying edges, emit every div+1.
  task automatic model_edge();
    int stall;
    int acc_ok;
    m_tick = 0;
    if (reset) begin
      model_reset();
      return;
    end
    if (load) begin
      m_acc = int'(seed);
`ifdef TEST_PATTERN_GEN_LFSR_EN
      if (mode == 2'd3 && seed == 0) m_acc = 1;
`endif
      m_up = 1; m_pend = 0; m_cnt = 0; m_valid = 0; m_wrap = 0;
      return;
    end
    stall  = (m_valid != 0 && !out_ready) ? 1 : 0;
    acc_ok = (m_valid != 0 && out_ready) ? 1 : 0;
    m_wrap = 0;
    if (acc_ok != 0) m_valid = 0;
    if (en && stall == 0) begin
      m_cnt++;
      if (m_cnt == int'(div) + 1) begin
        m_cnt   = 0;
        m_tick  = 1;
        m_data  = lanes_of(m_acc);
        m_wrap  = m_pend;
        m_valid = 1;
        model_adv(int'(mode), int'(step), int'(seed));
      end
    end
  endtask

  task automatic cycle(input logic e, input logic l, input logic r);
    en = e; load = l; out_ready = r;
    @(posedge clk);
    model_edge();
    #1;
    check("valid", out_valid, m_valid);
    check("wrap", wrap, m_wrap);
    if (m_valid != 0) check("data", out_data, m_data);
    if (m_tick != 0) begin
      cap_d.push_back(out_data);
      cap_w.push_back(wrap);
    end
  endtask

  initial begin
    int nv, nw, wi;
    logic [DW-1:0] pre_ch0;
    logic [CH*DW-1:0] pre;
    model_reset();

    // reset held with en=1 and clock running
    repeat (3) begin
      cycle(1'b1, 1'b0, 1'b1);
      check("rst_data", out_data, 0);
    end
    reset = 1'b0;
    #1;
    check("rel_data", out_data, 0);
    check("rel_valid", out_valid, 0);
    check("rel_wrap", wrap, 0);

    // increment, div 0, ready held
    mode = 2'd0; step = 10'd1; seed = 10'd0; div = 8'd0;
    cycle(1'b1, 1'b1, 1'b1);
    cap_d.delete(); cap_w.delete();
    repeat (1026) cycle(1'b1, 1'b0, 1'b1);
    check("inc_count", cap_d.size(), 1026);
    if (cap_d.size() == 1026) begin
      tv = cap_d[0];
      check("inc_first_ch0", tv[DW-1:0], 0);
      check("inc_first_ch1", tv[2*DW-1:DW], 512);
      tv = cap_d[1023];
      check("inc_1023", tv[DW-1:0], 1023);
      check("inc_nowrap_1023", cap_w[1023], 0);
      tv = cap_d[1024];
      check("inc_after_wrap", tv[DW-1:0], 0);
      check("inc_wrap", cap_w[1024], 1);
    end

    // divider and stall
    mode = 2'd0; step = 10'd5; seed = 10'd10; div = 8'd3;
    cycle(1'b1, 1'b1, 1'b1);
    cap_d.delete(); cap_w.delete();
    nv = 0;
    repeat (12) begin
      cycle(1'b1, 1'b0, 1'b1);
      nv += int'(out_valid);
    end
    check("div_valid_count", nv, 3);
    pre = out_data;
    repeat (10) cycle(1'b1, 1'b0, 1'b0);
    check("stall_hold_data", out_data, pre);
    check("stall_hold_valid", out_valid, 1);
    repeat (12) cycle(1'b1, 1'b0, 1'b1);
    check("div_stall_count", cap_d.size(), 6);
    for (int i = 0; i < cap_d.size(); i++) begin
      tv = cap_d[i];
      check("div_seq", tv[DW-1:0], 10 + 5 * i);
    end

    // triangle
    mode = 2'd2; step = 10'd300; seed = 10'd0; div = 8'd0;
    cycle(1'b1, 1'b1, 1'b1);
    cap_d.delete(); cap_w.delete();
    repeat (10) cycle(1'b1, 1'b0, 1'b1);
    check("tri_count", cap_d.size(), 10);
    for (int i = 0; i < 10 && i < cap_d.size(); i++) begin
      tv = cap_d[i];
      check("tri_data", tv[DW-1:0], tri_exp[i]);
      check("tri_wrap", cap_w[i], tri_wr[i]);
    end

    // mode 3 from seed 0
    mode = 2'd3; step = 10'd1; seed = 10'd0; div = 8'd0;
    cycle(1'b1, 1'b1, 1'b1);
    cap_d.delete(); cap_w.delete();
    repeat (1025) cycle(1'b1, 1'b0, 1'b1);
    check("m3_count", cap_d.size(), 1025);
    if (cap_d.size() > 0) begin
      tv = cap_d[0];
`ifdef TEST_PATTERN_GEN_LFSR_EN
      check("m3_first", tv[DW-1:0], 1);
`else
      check("m3_first", tv[DW-1:0], 0);
`endif
    end
    nw = 0; wi = -1;
    for (int i = 0; i < cap_w.size(); i++) begin
      if (cap_w[i]) begin nw++; wi = i; end
    end
    check("m3_wrap_count", nw, 1);
`ifdef TEST_PATTERN_GEN_LFSR_EN
    check("m3_wrap_index", wi, 1023);
`else
    check("m3_wrap_index", wi, 1024);
`endif

    // load mid-stream
    mode = 2'd0; step = 10'd1; seed = 10'd5; div = 8'd2;
    cycle(1'b1, 1'b1, 1'b1);
    repeat (10) cycle(1'b1, 1'b0, 1'b1);
    seed = 10'd100;
    cycle(1'b1, 1'b1, 1'b1);
    check("ld_valid_drop", out_valid, 0);
    repeat (2) begin
      cycle(1'b1, 1'b0, 1'b1);
      check("ld_wait", out_valid, 0);
    end
    cycle(1'b1, 1'b0, 1'b1);
    check("ld_valid", out_valid, 1);
    pre_ch0 = out_data[DW-1:0];
    check("ld_first", pre_ch0, 100);

    // async reset during a stall
    mode = 2'd0; step = 10'd7; seed = 10'd33; div = 8'd0;
    cycle(1'b1, 1'b1, 1'b1);
    cycle(1'b1, 1'b0, 1'b1);
    repeat (3) cycle(1'b1, 1'b0, 1'b0);
    check("pre_rst_valid", out_valid, 1);
    #2;
    reset = 1'b1;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_data", out_data, 0);
    check("arst_wrap", wrap, 0);
    model_reset();
    repeat (2) cycle(1'b1, 1'b0, 1'b0);
    reset = 1'b0;

    // randomized segments
    repeat (30) begin
      div  = 8'($urandom_range(0, 3));
      mode = 2'($urandom_range(0, 3));
      step = ($urandom_range(0, 7) == 0) ? 10'd0 : DW'($urandom);
      seed = ($urandom_range(0, 3) == 0) ? 10'd0 : DW'($urandom);
      cycle(1'b1, 1'b1, 1'b1);
      repeat (150) begin
        if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 29) == 0) step = DW'($urandom);
        cycle($urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0,
              $urandom_range(0, 9) < 7);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
